pep_ldg_splitc_subs_link: RTL

- Credit-based SLR-crossing link between the main-side GLWE load splitter and the subsidiary GRAM writer.
- Upstream side: consumes the splitter's subsidiary command and data streams and returns the per-command done pulse.
- Downstream side: re-presents both streams with normal valid/ready handshakes.
- Crossing pipeline registers are unstallable; receive-side FIFOs absorb in-flight traffic, so no ready signal crosses the SLR combinationally.

---
 rtl/pep_common_param_pkg.sv | 17 +
 rtl/pep_ldg_link_credit_chan.sv | 126 ++++++++++++
 rtl/pep_ldg_splitc_subs_link.sv | 115 +++++++++++
 3 files changed

// File: rtl/pep_common_param_pkg.sv
// Shared constants and types for the PEP load-GLWE splitter SLR link.
package pep_common_param_pkg;

   localparam int MOD_Q_W                 = 32;
   localparam int GLWE_SPLITC_COEF        = 2;
   localparam int LOAD_GLWE_CMD_W         = 16;
   localparam int PEP_LDG_LINK_PIPE_DEPTH = 2;
   localparam int PEP_LDG_LINK_DATA_DEPTH = 8;
   localparam int PEP_LDG_LINK_CMD_DEPTH  = 4;

   // Credit events seen by a channel counter in one cycle.
   typedef struct packed {
      logic send;
      logic ret;
   } pep_ldg_link_credit_t;

endpackage

// File: rtl/pep_ldg_link_credit_chan.sv
// One credit-controlled SLR crossing: credit counter, forward pipe, receive FIFO, credit return pipe.
// Optional fault output is present when PEP_LDG_SPLITC_LINK_CHECK_EN is defined.
module pep_ldg_link_credit_chan
   import pep_common_param_pkg::*;
#(
   parameter int W          = 8,
   parameter int DEPTH      = 8,
   parameter int PIPE_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_vld,
   output logic         in_rdy,
   output logic [W-1:0] out_data,
   output logic         out_vld,
   input  logic         out_rdy
`ifdef PEP_LDG_SPLITC_LINK_CHECK_EN
   ,
   output logic         fault
`endif
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   pep_ldg_link_credit_t ev;
   logic [CNT_W-1:0] credit_reg, credit_next;
   logic             fwd_vld_reg  [PIPE_DEPTH];
   logic             fwd_vld_next [PIPE_DEPTH];
   logic [W-1:0]     fwd_data_reg [PIPE_DEPTH];
   logic [W-1:0]     fwd_data_next[PIPE_DEPTH];
   logic             ret_vld_reg  [PIPE_DEPTH];
   logic             ret_vld_next [PIPE_DEPTH];

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] mem_cnt_reg;
   logic             out_vld_reg;
   logic [W-1:0]     out_data_reg;
   logic             push, pop, load_out, mem_empty, mem_full, mem_rd, mem_wr;

   assign in_rdy  = (credit_reg != '0);
   assign ev.send = in_vld & in_rdy;
   assign ev.ret  = ret_vld_reg[PIPE_DEPTH-1];

   always_comb begin
      credit_next = credit_reg;
      case ({ev.send, ev.ret})
         2'b10:   credit_next = credit_reg - 1'b1;
         2'b01:   if (credit_reg != FULL_CNT) credit_next = credit_reg + 1'b1;
         default: credit_next = credit_reg;
      endcase
   end

   // Both crossing pipes shift unconditionally; nothing here can stall.
   for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign fwd_vld_next[gi]  = ev.send;
         assign fwd_data_next[gi] = in_data;
         assign ret_vld_next[gi]  = pop;
      end else begin : g_body
         assign fwd_vld_next[gi]  = fwd_vld_reg[gi-1];
         assign fwd_data_next[gi] = fwd_data_reg[gi-1];
         assign ret_vld_next[gi]  = ret_vld_reg[gi-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_reg <= FULL_CNT;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            fwd_vld_reg[i] <= 1'b0;
            ret_vld_reg[i] <= 1'b0;
         end
      end else begin
         credit_reg  <= credit_next;
         fwd_vld_reg <= fwd_vld_next;
         ret_vld_reg <= ret_vld_next;
      end
   end

   always_ff @(posedge clk) begin
      fwd_data_reg <= fwd_data_next;
   end

   // Receive FIFO: RAM plus a registered head; an arrival into an idle FIFO bypasses the RAM.
   assign push      = fwd_vld_reg[PIPE_DEPTH-1];
   assign pop       = out_vld_reg & out_rdy;
   assign load_out  = ~out_vld_reg | pop;
   assign mem_empty = (mem_cnt_reg == '0);
   assign mem_full  = (mem_cnt_reg == FULL_CNT);
   assign mem_rd    = load_out & ~mem_empty;
   assign mem_wr    = push & ~mem_full & ~(load_out & mem_empty);

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr_reg] <= fwd_data_reg[PIPE_DEPTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         mem_cnt_reg  <= '0;
         out_vld_reg  <= 1'b0;
         out_data_reg <= '0;
      end else begin
         if (mem_wr) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
         if (mem_rd) rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
         mem_cnt_reg <= mem_cnt_reg + CNT_W'(mem_wr) - CNT_W'(mem_rd);
         if (load_out) begin
            out_vld_reg  <= ~mem_empty | push;
            out_data_reg <= mem_empty ? fwd_data_reg[PIPE_DEPTH-1] : mem[rd_ptr_reg];
         end
      end
   end

   assign out_vld  = out_vld_reg;
   assign out_data = out_data_reg;

`ifdef PEP_LDG_SPLITC_LINK_CHECK_EN
   assign fault = (push & mem_full) | (ev.ret & ~ev.send & (credit_reg == FULL_CNT));
`endif

endmodule

// File: rtl/pep_ldg_splitc_subs_link.sv
// Credit-based SLR link from the GLWE load splitter to the subsidiary GRAM writer.
// Define PEP_LDG_SPLITC_LINK_CHECK_EN to enable the sticky protocol error checker.
module pep_ldg_splitc_subs_link
   import pep_common_param_pkg::*;
#(
   parameter int OP_W       = MOD_Q_W,
   parameter int COEF_NB    = GLWE_SPLITC_COEF,
   parameter int CMD_W      = LOAD_GLWE_CMD_W,
   parameter int PIPE_DEPTH = PEP_LDG_LINK_PIPE_DEPTH,
   parameter int DATA_DEPTH = PEP_LDG_LINK_DATA_DEPTH,
   parameter int CMD_DEPTH  = PEP_LDG_LINK_CMD_DEPTH
) (
   input  logic                    clk,
   input  logic                    a_rst,
   input  logic [CMD_W-1:0]        subs_cmd,
   input  logic                    subs_cmd_vld,
   output logic                    subs_cmd_rdy,
   output logic                    subs_cmd_done,
   input  logic [COEF_NB*OP_W-1:0] subs_data,
   input  logic                    subs_data_vld,
   output logic                    subs_data_rdy,
   output logic [CMD_W-1:0]        out_cmd,
   output logic                    out_cmd_vld,
   input  logic                    out_cmd_rdy,
   input  logic                    out_cmd_done,
   output logic [COEF_NB*OP_W-1:0] out_data,
   output logic                    out_data_vld,
   input  logic                    out_data_rdy,
   output logic                    error
);
   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_pipe
      $fatal(1, "PIPE_DEPTH must be in 1..8");
   end
   if (DATA_DEPTH < 2*PIPE_DEPTH + 2) begin : g_bad_data_depth
      $fatal(1, "DATA_DEPTH must be >= 2*PIPE_DEPTH+2");
   end
   if (CMD_DEPTH < 2) begin : g_bad_cmd_depth
      $fatal(1, "CMD_DEPTH must be >= 2");
   end

   logic done_reg  [PIPE_DEPTH];
   logic done_next [PIPE_DEPTH];
`ifdef PEP_LDG_SPLITC_LINK_CHECK_EN
   logic data_fault, cmd_fault;
`endif

   pep_ldg_link_credit_chan #(
      .W(COEF_NB*OP_W), .DEPTH(DATA_DEPTH), .PIPE_DEPTH(PIPE_DEPTH)
   ) u_data_chan (
      .clk(clk), .rst(a_rst),
      .in_data(subs_data), .in_vld(subs_data_vld), .in_rdy(subs_data_rdy),
      .out_data(out_data), .out_vld(out_data_vld), .out_rdy(out_data_rdy)
`ifdef PEP_LDG_SPLITC_LINK_CHECK_EN
      , .fault(data_fault)
`endif
   );

   pep_ldg_link_credit_chan #(
      .W(CMD_W), .DEPTH(CMD_DEPTH), .PIPE_DEPTH(PIPE_DEPTH)
   ) u_cmd_chan (
      .clk(clk), .rst(a_rst),
      .in_data(subs_cmd), .in_vld(subs_cmd_vld), .in_rdy(subs_cmd_rdy),
      .out_data(out_cmd), .out_vld(out_cmd_vld), .out_rdy(out_cmd_rdy)
`ifdef PEP_LDG_SPLITC_LINK_CHECK_EN
      , .fault(cmd_fault)
`endif
   );

   // One register per stage keeps back-to-back done pulses distinct.
   for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_done
      if (gi == 0) begin : g_head
         assign done_next[gi] = out_cmd_done;
      end else begin : g_body
         assign done_next[gi] = done_reg[gi-1];
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) done_reg[i] <= 1'b0;
      end else begin
         done_reg <= done_next;
      end
   end

   assign subs_cmd_done = done_reg[PIPE_DEPTH-1];

`ifdef PEP_LDG_SPLITC_LINK_CHECK_EN
   localparam int OUTST_W = $clog2(CMD_DEPTH + PIPE_DEPTH + 1);
   logic [OUTST_W-1:0] outst_reg;
   logic               err_reg, cmd_acc, done_fault;

   assign cmd_acc    = subs_cmd_vld & subs_cmd_rdy;
   assign done_fault = subs_cmd_done & ~cmd_acc & (outst_reg == '0);

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         outst_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         case ({cmd_acc, subs_cmd_done})
            2'b10:   if (outst_reg != '1) outst_reg <= outst_reg + 1'b1;
            2'b01:   if (outst_reg != '0) outst_reg <= outst_reg - 1'b1;
            default: outst_reg <= outst_reg;
         endcase
         if (data_fault | cmd_fault | done_fault) err_reg <= 1'b1;
      end
   end

   assign error = err_reg;
`else
   assign error = 1'b0;
`endif

endmodule
